// File: rtl/rst_m_multi.sv
// Matrix-register status table: busy bit + producer tag per register, one dispatch
// allocation, NWB tag-checked writeback releases and NSRC bypassed lookups per cycle.
module rst_m_multi #(
   parameter  int NREG  = 64,
   parameter  int TAG_W = 2,
   parameter  int NWB   = 2,
   parameter  int NSRC  = 2,
   localparam int SEL_W = $clog2(NREG)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  flush,
   input  logic                  di_write,
   input  logic [SEL_W-1:0]      di_sel,
   input  logic [TAG_W-1:0]      di_tag,
   input  logic [NWB-1:0]        wb_write,
   input  logic [NWB*SEL_W-1:0]  wb_sel,
   input  logic [NWB*TAG_W-1:0]  wb_tag,
   input  logic [NSRC*SEL_W-1:0] src_sel,
   output logic [NSRC-1:0]       src_busy,
   output logic [NSRC*TAG_W-1:0] src_tag,
   output logic [NREG-1:0]       busy_vec,
   output logic [SEL_W:0]        busy_cnt,
   output logic                  full
);

   localparam logic [SEL_W:0] LP_NREG = (SEL_W+1)'(NREG);

   logic [NREG-1:0]  r_busy;
   logic [TAG_W-1:0] r_tag [NREG];
   logic [SEL_W:0]   r_cnt;

   logic [NREG-1:0]  w_rel;
   logic [NREG-1:0]  w_di_hot;
   logic [NREG-1:0]  w_rel_eff;
   logic             w_di_new;
   logic [SEL_W:0]   w_cnt_nxt;

   function automatic logic in_range(input logic [SEL_W-1:0] s);
      return {1'b0, s} < LP_NREG;
   endfunction

   function automatic logic [SEL_W:0] popcnt(input logic [NREG-1:0] v);
      logic [SEL_W:0] c;
      c = '0;
      for (int k = 0; k < NREG; k++) c = c + {{SEL_W{1'b0}}, v[k]};
      return c;
   endfunction

   // A register is released when any writeback port matches its live tag.
   always_comb begin
      w_rel = '0;
      for (int i = 0; i < NWB; i++) begin
         if (wb_write[i] && in_range(wb_sel[i*SEL_W +: SEL_W]) &&
             r_busy[wb_sel[i*SEL_W +: SEL_W]] &&
             (r_tag[wb_sel[i*SEL_W +: SEL_W]] == wb_tag[i*TAG_W +: TAG_W]))
            w_rel[wb_sel[i*SEL_W +: SEL_W]] = 1'b1;
      end
   end

   // Dispatch to the same register wins over a same-cycle release.
   always_comb begin
      w_di_hot = '0;
      if (di_write && in_range(di_sel)) w_di_hot[di_sel] = 1'b1;
      w_di_new  = |(w_di_hot & ~r_busy);
      w_rel_eff = w_rel & ~w_di_hot;
      w_cnt_nxt = r_cnt + {{SEL_W{1'b0}}, w_di_new} - popcnt(w_rel_eff);
   end

   always_comb begin
      src_busy = '0;
      src_tag  = '0;
      for (int j = 0; j < NSRC; j++) begin
         if (in_range(src_sel[j*SEL_W +: SEL_W]) && r_busy[src_sel[j*SEL_W +: SEL_W]] &&
             !w_rel[src_sel[j*SEL_W +: SEL_W]]) begin
            src_busy[j]                = 1'b1;
            src_tag[j*TAG_W +: TAG_W]  = r_tag[src_sel[j*SEL_W +: SEL_W]];
         end
      end
   end

   // Flush frees every entry but leaves stale tags; lookups mask them while not busy.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_busy <= '0;
         r_cnt  <= '0;
         for (int r = 0; r < NREG; r++) r_tag[r] <= '0;
      end else if (flush) begin
         r_busy <= '0;
         r_cnt  <= '0;
      end else begin
         r_busy <= (r_busy & ~w_rel_eff) | w_di_hot;
         r_cnt  <= w_cnt_nxt;
         if (|w_di_hot) r_tag[di_sel] <= di_tag;
      end
   end

   assign busy_vec = r_busy;
   assign busy_cnt = r_cnt;
   assign full     = (r_cnt == LP_NREG);

endmodule

// File: doc/rst_m_multi.md
# rst_m_multi

Parametrised matrix-register status table for the tensor-core dispatch stage. For each architectural matrix register it tracks a busy bit and the tag of the functional unit that will produce the register's value. It accepts one dispatch allocation and NWB tag-checked writeback releases per cycle, and answers NSRC source-operand lookups with same-cycle writeback bypass. It also supports a pipeline flush and keeps a count of busy registers for dispatch throttling.

## Interface
- NREG, 64: number of matrix registers; SEL_W = $clog2(NREG).
- TAG_W, 2: producer-tag width.
- NWB, 2: number of writeback ports.
- NSRC, 2: number of source-lookup ports.
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- flush  input  1  clears every entry at the next edge.
- di_write  input  1  dispatch allocates register di_sel.
- di_sel  input  SEL_W  destination register of the dispatched instruction.
- di_tag  input  TAG_W  producer tag for di_sel.
- wb_write  input  NWB  per-port writeback valid.
- wb_sel  input  NWB*SEL_W  per-port destination register.
- wb_tag  input  NWB*TAG_W  per-port producer tag.
- src_sel  input  NSRC*SEL_W  per-port lookup register.
- src_busy  output  NSRC  combinational: the looked-up register is pending.
- src_tag  output  NSRC*TAG_W  combinational: pending producer tag; 0 when not busy.
- busy_vec  output  NREG  registered busy bits.
- busy_cnt  output  SEL_W+1  registered population count of busy_vec.
- full  output  1  busy_cnt == NREG.

## Operation
- Entry state: busy[r] and tag[r]. On reset all busy bits are 0 and all tags are 0, so busy_vec=0, busy_cnt=0 and full=0.
- Dispatch: when di_write=1, the next state of entry di_sel is busy=1, tag=di_tag. Re-dispatching to an entry that is already busy overwrites its tag (WAW rename); busy_cnt does not change in that case.
- Writeback on port i: when wb_write[i]=1, busy[wb_sel[i]] is cleared only if the entry is busy and tag[wb_sel[i]]==wb_tag[i]. A stale writeback, one whose tag mismatches or whose entry is already free, is ignored. The tag field keeps its value on release.
- Multiple writeback ports hitting the same register in one cycle: the release happens if any port matches. This is not an error.
- Dispatch and a matching writeback to the same register in one cycle: dispatch wins. The end state is busy=1 with tag=di_tag, and busy_cnt does not change.
- Flush: the next state is all entries free and busy_cnt=0. Flush overrides both dispatch and writeback in the same cycle.
- RST takes priority over flush and has the same effect. Asserting RST mid-operation discards all pending tags.
- Lookup on port j: src_busy[j] equals busy[src_sel[j]] AND NOT (a writeback this cycle matches that register and its current tag). src_tag[j] is tag[src_sel[j]] when src_busy[j]=1, otherwise 0.
- Lookups do not see a same-cycle dispatch. Dispatch is responsible for intra-bundle dependencies.
- busy_cnt is updated incrementally: +1 if the dispatch targets a free entry, −1 for each distinct register released. Net change per cycle is in the range −NWB to +1. Flush and reset set it to 0. The result can never leave the range 0 to NREG.
- Out-of-range selects (≥NREG, when NREG is not a power of 2) are ignored on the write side and return busy=0 on lookup.

## Timing
- State updates take 1 cycle: dispatch or writeback at edge N is visible on busy_vec, busy_cnt and full after edge N.
- Lookup outputs are purely combinational from src_sel, current state, and the wb_* inputs. There is no combinational path from the di_* inputs.
- There is no handshake. Every port is single-cycle fire-and-forget, and the block never stalls. The dispatch unit must use full or src_busy to throttle itself.

## Test plan
- Reset then lookup: assert RST for 2 cycles, then src_sel=5 → src_busy=0, src_tag=0, busy_vec=0, busy_cnt=0.
- Allocate and release: dispatch reg 5 with tag 2; next cycle src_busy=1, src_tag=2, busy_cnt=1. Writeback reg 5 with tag 2 → same-cycle src_busy=0 (bypass); next cycle busy_vec[5]=0, busy_cnt=0.
- WAW stale writeback: dispatch r3 with tag 1, then r3 with tag 3; writeback r3 with tag 1 → r3 stays busy with tag 3 and busy_cnt=1. Writeback r3 with tag 3 → r3 is freed.
- Simultaneous events: r7 busy with tag 0; in the same cycle dispatch r7 with tag 2, writeback r7 with tag 0, and writeback on port 1 for r9 (busy, matching tag) → r7 is busy with tag 2, r9 is freed, and busy_cnt decreases by 1.
- Fill and full: dispatch all 64 registers → full=1 and busy_cnt=64. One matching writeback → full=0 and busy_cnt=63.
- Flush priority: 10 registers busy; in the same cycle assert flush, dispatch r0, and writeback r1 with a matching tag → next cycle busy_vec=0, busy_cnt=0, full=0.
